pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It decides, every cycle, whether the PC and the IF/ID register advance, whether ID/EX receives a bubble, and whether younger instructions are flushed after a taken BEQ or a JUMP. It complements the ID-stage forwarding selects (which only cover ALU results) by stalling on load-use hazards. It also owns an external halt and two 16-bit saturating performance counters.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles spent in FLUSH after a redirect, legal range 1–7.

Ports (clock and reset are one clock domain, with reset asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_instr`  in  32  instruction currently in IF/ID
- `ex_opcode`  in  6  opcode in ID/EX
- `ex_rwd`  in  5  destination register in ID/EX
- `ex_branch_taken`  in  1  BEQ in EX resolved taken
- `halt_req`  in  1  external halt request (level)
- `pc_we`  out  1  PC register write enable
- `pc_redirect`  out  1  PC takes the branch/jump target this cycle
- `ifid_we`  out  1  IF/ID write enable
- `ifid_flush`  out  1  load NOP into IF/ID
- `idex_bubble`  out  1  load NOP (opcode 0, rwd 0) into ID/EX
- `state_o`  out  2  current FSM state
- `stall_cnt`  out  16  load-use stall cycles, saturating
- `flush_cnt`  out  16  redirects taken, saturating

## Operation
- ID field decode uses the same rules as the ID stage:
  - rs = instr[20:16].
  - rt = instr[25:21] for SDW, BEQ and LDW; otherwise instr[15:11].
  - JUMP is decoded from the opcode `JUMP`.
- Load-use hazard: asserted when `ex_opcode==LDW`, `ex_rwd!=0`, and `ex_rwd` equals rs or rt. The rs match is ignored for JUMP.
- FSM states (encoding in the package): RUN=0, FLUSH=1, HALT=2.
- RUN, checked in priority order:
  1. `ex_branch_taken`: `pc_redirect=1`, `pc_we=1`, `ifid_flush=1`, `idex_bubble=1`. Load counter with FLUSH_CYCLES-1; go to FLUSH, or stay in RUN if FLUSH_CYCLES==1. `flush_cnt` increments.
  2. ID opcode is JUMP: `pc_redirect=1`, `pc_we=1`, `ifid_flush=1`. Same counter/state rule as item 1. `flush_cnt` increments.
  3. `halt_req`: `pc_we=0`, `ifid_we=0`, `idex_bubble=1`; go to HALT.
  4. Load-use: `pc_we=0`, `ifid_we=0`, `idex_bubble=1`; stay in RUN. `stall_cnt` increments.
  5. Otherwise: `pc_we=1`, `ifid_we=1`, all other controls 0.
- FLUSH:
  - `pc_we=1`, `ifid_flush=1`, `idex_bubble=1`, `pc_redirect=0`.
  - Counter decrements; return to RUN when it reaches 0.
  - `halt_req` is deferred until RUN.
  - A new `ex_branch_taken` cannot occur because EX holds a bubble; if it is asserted anyway, ignore it.
- HALT:
  - `pc_we=0`, `ifid_we=0`, `idex_bubble=1`.
  - Return to RUN the cycle after `halt_req` drops. No stall-count increment.
- Counters saturate at 0xFFFF and do not wrap.
- All control outputs are combinational from state and inputs; state, the flush counter and the perf counters are registered.

## Timing
- Reset (asynchronous, `rst_n`=0) puts the FSM in RUN with the flush counter at 0 and `stall_cnt=flush_cnt=0`.
- Control outputs during reset (RUN with no inputs active): `pc_we=1`, `ifid_we=1`, all others 0.
- Decisions take effect in the same cycle as detection; the registered consequence appears at the next `clk` rising edge.
- A load-use stall lasts exactly one cycle. The next cycle sees a bubble in EX, so the hazard clears and MEM-stage forwarding supplies the value.
- A redirect costs the redirect cycle plus FLUSH_CYCLES-1 FLUSH cycles.
- Simultaneous events:
  - Branch taken plus load-use: the branch wins and the stall is not counted.
  - Branch taken plus halt: the branch wins and HALT follows FLUSH.
- Reset mid-FLUSH or mid-HALT: immediate return to RUN; counters clear.

## Structure
- Shared package / `def.v`:
  - Opcode constants (LDW, SDW, BEQ, JUMP) come from here.
  - Add the state encodings `ST_RUN`, `ST_FLUSH`, `ST_HALT` and `NOP_OPCODE`.
- One sub-module: `sat_counter16` (enable, clear, 16-bit saturating), instantiated twice.

## Test plan
- LDW writing r3 in EX, ID instruction with rs=3 → one cycle of `pc_we=0`, `ifid_we=0`, `idex_bubble=1`; `stall_cnt`=1; next cycle normal flow.
- Same as above with `ex_rwd`=0, or with `ex_opcode` not LDW → no stall.
- `ex_branch_taken` pulse, FLUSH_CYCLES=2 → cycle0 `pc_redirect=1` with flushes; cycle1 in FLUSH; cycle2 RUN; `flush_cnt`=1.
- JUMP in ID at the same time as load-use → redirect only, `stall_cnt` unchanged.
- `halt_req` held 5 cycles → `state_o`=HALT for 5 cycles, `pc_we=0` throughout; RUN the cycle after release.
- Force 65537 load-use stalls → `stall_cnt`=0xFFFF. Assert `rst_n`=0 mid-FLUSH → `state_o`=0 and both counters 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: opcodes, FSM
// state encodings and the ID-stage register-field decode rule.
package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] NOP_OPCODE = 6'h00;
  localparam logic [5:0] JUMP       = 6'h02;
  localparam logic [5:0] BEQ        = 6'h04;
  localparam logic [5:0] LDW        = 6'h23;
  localparam logic [5:0] SDW        = 6'h2b;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // SDW, BEQ and LDW carry their second source register in instr[25:21].
  function automatic logic rt_in_high_field(input logic [5:0] op);
    return (op == SDW) || (op == BEQ) || (op == LDW);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at 0xFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'h0000;
    end else if (en && (cnt_q != 16'hffff)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump redirect with
// a fixed-length flush window, external halt, and stall/redirect counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic [5:0]  ex_opcode,
  input  logic [4:0]  ex_rwd,
  input  logic        ex_branch_taken,
  input  logic        halt_req,
  output logic        pc_we,
  output logic        pc_redirect,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam state_e     REDIR_STATE = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt;
  logic        id_jump;
  logic        load_use;
  logic        stall_inc, flush_inc;

  always_comb begin
    id_op   = id_instr[31:26];
    id_rs   = id_instr[20:16];
    id_rt   = rt_in_high_field(id_op) ? id_instr[25:21] : id_instr[15:11];
    id_jump = (id_op == JUMP);
    // A JUMP reads no rs operand, so only the rt match can stall it.
    load_use = (ex_opcode == LDW) && (ex_rwd != 5'd0) &&
               (((ex_rwd == id_rs) && !id_jump) || (ex_rwd == id_rt));
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_we       = 1'b0;
    pc_redirect = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          pc_redirect = 1'b1;
          pc_we       = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          fcnt_d      = FLUSH_LOAD;
          state_d     = REDIR_STATE;
          flush_inc   = 1'b1;
        end else if (id_jump) begin
          pc_redirect = 1'b1;
          pc_we       = 1'b1;
          ifid_flush  = 1'b1;
          fcnt_d      = FLUSH_LOAD;
          state_d     = REDIR_STATE;
          flush_inc   = 1'b1;
        end else if (halt_req) begin
          idex_bubble = 1'b1;
          state_d     = ST_HALT;
        end else if (load_use) begin
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      ST_FLUSH: begin
        // EX holds a bubble here, so a stray branch_taken is ignored and
        // halt_req waits until RUN.
        pc_we       = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        fcnt_d      = (fcnt_q != 3'd0) ? fcnt_q - 3'd1 : 3'd0;
        if (fcnt_q <= 3'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        idex_bubble = 1'b1;
        if (!halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state_o = state_q;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule
